jk_seq_driver: RTL and testbench



---
 rtl/jk_seq_driver.sv | 173 +++++++++++++++++
 tb/tb_jk_seq_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// Control stage for a negedge JK-flip-flop counter bank: debounces the step button,
// holds a programmable next-state table, drives J/K plus one CK pulse per step and verifies the landing state.
module jk_seq_driver #(
  parameter int WIDTH      = 3,
  parameter int DEPTH      = 2**WIDTH,
  parameter int DEB_CYCLES = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             step_btn,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] Qfb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             CK,
  output logic             busy,
  output logic             wr_drop,
  output logic             err
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_PULSE_HI = 3'd2,
    S_PULSE_LO = 3'd3,
    S_CHECK    = 3'd4
  } state_e;

  // Minimal JK excitation: set bits that rise, reset bits that fall, hold the rest.
  function automatic logic [2*WIDTH-1:0] jk_excite(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] nxt);
    return {nxt & ~cur, ~nxt & cur};
  endfunction

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             req_q, req_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             ck_q, ck_d;
  logic             busy_q, busy_d;
  logic             wr_drop_q, wr_drop_d;
  logic             err_q, err_d;
  logic             wr_ok_s;
  logic [WIDTH-1:0] tbl_q [DEPTH];

  // Debounce counter and level: flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d     = ~deb_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
    req_d = deb_d & ~deb_q;
  end

  // Step sequencer next state and registered output values.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    j_d     = j_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        j_d = '0;
        k_d = '0;
        if (req_q) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        // Lookup happens here so a write accepted in IDLE on the request edge is seen.
        t_d        = tbl_q[Qfb];
        {j_d, k_d} = jk_excite(Qfb, tbl_q[Qfb]);
        state_d    = S_PULSE_HI;
      end
      S_PULSE_HI: begin
        state_d = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (Qfb != t_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        j_d     = '0;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        j_d     = '0;
        k_d     = '0;
        state_d = S_IDLE;
      end
    endcase
    ck_d      = (state_d == S_PULSE_HI);
    busy_d    = (state_d != S_IDLE);
    wr_ok_s   = we & (state_q == S_IDLE);
    wr_drop_d = we & (state_q != S_IDLE);
  end

  // Synchroniser, debouncer and sequencer registers.
  always_ff @(posedge C) begin
    if (R) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      req_q     <= 1'b0;
      state_q   <= S_IDLE;
      t_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ck_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      req_q     <= req_d;
      state_q   <= state_d;
      t_q       <= t_d;
      j_q       <= j_d;
      k_q       <= k_d;
      ck_q      <= ck_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      err_q     <= err_d;
    end
  end

  // Next-state table; reset restores a plain binary count.
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= WIDTH'(i + 1);
      end
    end else if (wr_ok_s) begin
      tbl_q[waddr] <= wdata;
    end
  end

  assign J       = j_q;
  assign K       = k_q;
  assign CK      = ck_q;
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;
  assign err     = err_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench for jk_seq_driver with a behavioural negedge JK bank on the feedback path.
module tb_jk_seq_driver;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       step_btn = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = 3'd0;
  logic [2:0] wdata = 3'd0;
  logic [2:0] Qfb;
  logic [2:0] J, K;
  logic       CK, busy, wr_drop, err;

  logic [2:0] bank_q = 3'd0;
  logic       bank_ld = 1'b0;
  logic [2:0] bank_ld_val = 3'd0;
  logic       stuck = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int ck_hi_cnt = 0;
  int busy_cnt = 0;
  logic [2:0] cap_j = 3'd0, cap_k = 3'd0;

  jk_seq_driver #(.WIDTH(3), .DEPTH(8), .DEB_CYCLES(4)) dut (
    .C(C), .R(R), .step_btn(step_btn), .we(we), .waddr(waddr), .wdata(wdata),
    .Qfb(Qfb), .J(J), .K(K), .CK(CK), .busy(busy), .wr_drop(wr_drop), .err(err)
  );

  always #5 C = ~C;

  assign Qfb = stuck ? 3'd0 : bank_q;

  // JK bank: updates on CK falling edge; bank_ld preloads it
  always @(negedge CK or posedge bank_ld) begin
    if (bank_ld) bank_q <= bank_ld_val;
    else begin
      for (int b = 0; b < 3; b++) begin
        case ({J[b], K[b]})
          2'b01:   bank_q[b] <= 1'b0;
          2'b10:   bank_q[b] <= 1'b1;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  always @(negedge C) begin
    if (CK === 1'b1) begin
      ck_hi_cnt++;
      cap_j = J;
      cap_k = K;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    step_btn = 1'b0;
    R = 1'b1;
    repeat (3) @(negedge C);
    R = 1'b0;
  endtask

  task automatic set_bank(input logic [2:0] v);
    bank_ld_val = v;
    bank_ld = 1'b1;
    #1;
    bank_ld = 1'b0;
  endtask

  task automatic press();
    step_btn = 1'b1;
    repeat (12) @(negedge C);
    step_btn = 1'b0;
    repeat (12) @(negedge C);
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge C);
    we = 1'b0;
  endtask

  task automatic wait_ck_high();
    int n;
    n = 0;
    while (CK !== 1'b1 && n < 40) begin
      @(negedge C);
      n++;
    end
    check_eq("wait_ck_high", CK, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, b0;
    logic [2:0] e;

    do_reset();
    check_eq("rst_J", J, 0);
    check_eq("rst_K", K, 0);
    check_eq("rst_CK", CK, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_drop", wr_drop, 0);
    check_eq("rst_err", err, 0);

    // Test 1: natural binary count through all eight states
    for (int i = 0; i < 8; i++) begin
      c0 = ck_hi_cnt; b0 = busy_cnt;
      press();
      e = 3'(i + 1);
      check_eq("t1_qfb", Qfb, e);
      check_eq("t1_ck_pulses", ck_hi_cnt - c0, 1);
      check_eq("t1_busy_cycles", busy_cnt - b0, 4);
      check_eq("t1_err", err, 0);
    end

    // Test 2: bouncing button yields exactly one step
    do_reset();
    set_bank(3'd0);
    c0 = ck_hi_cnt;
    for (int i = 0; i < 20; i++) begin
      step_btn = ((i / 3) % 2 == 0);
      @(negedge C);
    end
    step_btn = 1'b1;
    repeat (10) @(negedge C);
    step_btn = 1'b0;
    repeat (12) @(negedge C);
    check_eq("t2_qfb", Qfb, 3'b001);
    check_eq("t2_ck_pulses", ck_hi_cnt - c0, 1);

    // Test 3: programmed sequence 0->5->3->0
    do_reset();
    set_bank(3'd0);
    wr(3'd0, 3'd5);
    wr(3'd5, 3'd3);
    wr(3'd3, 3'd0);
    press();
    check_eq("t3_qfb_1", Qfb, 3'b101);
    check_eq("t3_J_1", cap_j, 3'b101);
    check_eq("t3_K_1", cap_k, 3'b000);
    press();
    check_eq("t3_qfb_2", Qfb, 3'b011);
    check_eq("t3_J_2", cap_j, 3'b010);
    check_eq("t3_K_2", cap_k, 3'b100);
    press();
    check_eq("t3_qfb_3", Qfb, 3'b000);
    check_eq("t3_err", err, 0);

    // Test 4: write during PULSE_HI is dropped
    do_reset();
    set_bank(3'd0);
    step_btn = 1'b1;
    wait_ck_high();
    we = 1'b1; waddr = 3'd0; wdata = 3'd7;
    @(negedge C);
    we = 1'b0;
    check_eq("t4_wr_drop_hi", wr_drop, 1);
    @(negedge C);
    check_eq("t4_wr_drop_lo", wr_drop, 0);
    step_btn = 1'b0;
    repeat (16) @(negedge C);
    check_eq("t4_qfb_a", Qfb, 3'b001);
    set_bank(3'd0);
    press();
    check_eq("t4_qfb_b", Qfb, 3'b001);

    // Test 5: stuck feedback sets sticky err
    do_reset();
    set_bank(3'd0);
    stuck = 1'b1;
    press();
    check_eq("t5_err_set", err, 1);
    stuck = 1'b0;
    press();
    check_eq("t5_qfb", Qfb, 3'b010);
    check_eq("t5_err_sticky", err, 1);

    // Test 6: reset during PULSE_HI (err still set from test 5)
    wr(3'd2, 3'd7);
    step_btn = 1'b1;
    wait_ck_high();
    check_eq("t6_J_pre", J, 3'b101);
    R = 1'b1;
    step_btn = 1'b0;
    @(negedge C);
    check_eq("t6_CK", CK, 0);
    check_eq("t6_J", J, 0);
    check_eq("t6_K", K, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_bank_hold", Qfb, 3'b010);
    repeat (2) @(negedge C);
    R = 1'b0;
    press();
    check_eq("t6_table_revert", Qfb, 3'b011);
    check_eq("t6_err_after", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
